// File: rtl/store_buffer.sv
// Posted-write store buffer: circular FIFO of stores draining into data memory
// when no load is using the port, with youngest-match load forwarding.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       St_Valid,
    input  logic [ADDR_W-1:0]          St_Addr,
    input  logic [DATA_W-1:0]          St_Data,
    output logic                       St_Ready,
    input  logic                       Ld_Valid,
    input  logic [ADDR_W-1:0]          Ld_Addr,
    output logic                       Ld_Hit,
    output logic [DATA_W-1:0]          Ld_Data,
    output logic [ADDR_W-1:0]          Mem_Addr,
    output logic [DATA_W-1:0]          Mem_WriteData,
    output logic                       Mem_Write,
    output logic                       Empty,
    output logic [$clog2(DEPTH):0]     Count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PW-1:0]     head, tail, idx;
    logic [CW-1:0]     count;
    logic              enq, drain;

    // Ready looks only at registered occupancy, so a same-cycle drain never frees a slot.
    assign St_Ready      = count < CW'(DEPTH);
    assign Empty         = (count == '0);
    assign enq           = St_Valid && St_Ready;
    assign drain         = !Empty && !Ld_Valid;
    assign Mem_Write     = drain;
    assign Mem_Addr      = addr_q[head];
    assign Mem_WriteData = data_q[head];
    assign Count         = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq)   tail <= tail + 1'b1;
            if (drain) head <= head + 1'b1;
            count <= count + CW'(enq) - CW'(drain);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && enq) begin
            addr_q[tail] <= St_Addr;
            data_q[tail] <= St_Data;
        end
    end

    // Walk oldest to youngest so the last match (youngest store) wins.
    always_comb begin
        Ld_Hit  = 1'b0;
        Ld_Data = '0;
        idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (Ld_Valid && (CW'(i) < count) && (addr_q[idx] == Ld_Addr)) begin
                Ld_Hit  = 1'b1;
                Ld_Data = data_q[idx];
            end
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_store_buffer;
    localparam int DEPTH = 4;

    logic        clk = 0;
    logic        rst;
    logic        St_Valid, Ld_Valid;
    logic [31:0] St_Addr, St_Data, Ld_Addr;
    logic        St_Ready, Ld_Hit, Mem_Write, Empty;
    logic [31:0] Ld_Data, Mem_Addr, Mem_WriteData;
    logic [2:0]  Count;

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .St_Valid(St_Valid), .St_Addr(St_Addr), .St_Data(St_Data), .St_Ready(St_Ready),
        .Ld_Valid(Ld_Valid), .Ld_Addr(Ld_Addr), .Ld_Hit(Ld_Hit), .Ld_Data(Ld_Data),
        .Mem_Addr(Mem_Addr), .Mem_WriteData(Mem_WriteData), .Mem_Write(Mem_Write),
        .Empty(Empty), .Count(Count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] a; logic [31:0] d; } ent_t;
    ent_t        q[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] dut_mem [logic [31:0]];
    int          checks = 0, fails = 0, drops = 0, nwrites = 0;
    bit          chk_on = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: queue of pending stores; memory commits at the negedge.
    always @(negedge clk) begin
        bit          exp_wr, hit;
        logic [31:0] fwd;
        exp_wr = (q.size() > 0) && !Ld_Valid;
        hit = 0; fwd = '0;
        if (Ld_Valid)
            for (int i = q.size() - 1; i >= 0; i--)
                if (!hit && q[i].a == Ld_Addr) begin hit = 1; fwd = q[i].d; end
        if (chk_on) begin
            chk("count", Count, q.size());
            chk("st_ready", St_Ready, q.size() < DEPTH);
            chk("empty", Empty, q.size() == 0);
            chk("mem_write", Mem_Write, exp_wr);
            chk("ld_hit", Ld_Hit, hit);
            chk("ld_data", Ld_Data, fwd);
            if (q.size() > 0) begin
                chk("mem_addr", Mem_Addr, q[0].a);
                chk("mem_wdata", Mem_WriteData, q[0].d);
            end
            if (Mem_Write === 1'b1) begin
                dut_mem[Mem_Addr] = Mem_WriteData;
                nwrites++;
            end
            if (!rst && St_Valid && q.size() == DEPTH) begin
                drops++;
                $display("protocol: store to full buffer dropped at %0t", $time);
            end
        end
        if (exp_wr) ref_mem[q[0].a] = q[0].d;
        if (rst) q.delete();
        else begin
            bit acc;
            acc = St_Valid && (q.size() < DEPTH);
            if (exp_wr) void'(q.pop_front());
            if (acc) q.push_back('{a: St_Addr, d: St_Data});
        end
    end

    task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                         input logic lv, input logic [31:0] la, input logic r);
        @(posedge clk); #1;
        St_Valid = sv; St_Addr = sa; St_Data = sd;
        Ld_Valid = lv; Ld_Addr = la; rst = r;
    endtask

    task automatic idle(); drive(0, 0, 0, 0, 0, 0); endtask
    task automatic at_neg(); @(negedge clk); #1; endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int w0;
        rst = 1; St_Valid = 0; St_Addr = 0; St_Data = 0; Ld_Valid = 0; Ld_Addr = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0; chk_on = 1;
        at_neg();
        chk("rst_count", Count, 0);
        chk("rst_empty", Empty, 1);
        chk("rst_ready", St_Ready, 1);
        chk("rst_memwr", Mem_Write, 0);

        // single store then drain
        drive(1, 5, 32'h23, 0, 0, 0);
        idle(); at_neg();
        chk("t1_count", Count, 1);
        chk("t1_wr", Mem_Write, 1);
        chk("t1_addr", Mem_Addr, 5);
        chk("t1_data", Mem_WriteData, 32'h23);
        idle(); at_neg();
        chk("t1_empty", Empty, 1);
        chk("t1_count0", Count, 0);

        // fill under continuous loads, then drain in order
        for (int i = 0; i < 4; i++) drive(1, i, 32'h10 + i, 1, 32'h99, 0);
        drive(0, 0, 0, 1, 32'h99, 0); at_neg();
        chk("t2_ready", St_Ready, 0);
        chk("t2_count", Count, 4);
        chk("t2_wr", Mem_Write, 0);
        for (int i = 0; i < 4; i++) begin
            idle(); at_neg();
            chk("t2_drain_wr", Mem_Write, 1);
            chk("t2_drain_addr", Mem_Addr, i);
            chk("t2_drain_data", Mem_WriteData, 32'h10 + i);
        end
        idle(); at_neg();
        chk("t2_empty", Empty, 1);

        // youngest-match forwarding
        drive(1, 7, 32'h2F, 1, 7, 0);
        drive(1, 7, 32'h1A, 1, 7, 0);
        drive(0, 0, 0, 1, 7, 0); at_neg();
        chk("t3_hit", Ld_Hit, 1);
        chk("t3_data", Ld_Data, 32'h1A);
        drive(0, 0, 0, 1, 8, 0); at_neg();
        chk("t3_miss", Ld_Hit, 0);
        chk("t3_miss_data", Ld_Data, 0);
        idle(); idle(); idle();

        // store while full and draining is dropped; next one accepted and wraps
        for (int i = 0; i < 4; i++) drive(1, 32'h20 + i, 32'hA0 + i, 1, 0, 0);
        drive(1, 32'h30, 32'hB5, 0, 0, 0); at_neg();
        chk("t4_count4", Count, 4);
        chk("t4_ready0", St_Ready, 0);
        chk("t4_wr", Mem_Write, 1);
        drive(1, 32'h31, 32'hB6, 0, 0, 0); at_neg();
        chk("t4_count3", Count, 3);
        chk("t4_ready1", St_Ready, 1);
        chk("t4_addr21", Mem_Addr, 32'h21);
        idle(); idle(); idle(); at_neg();
        chk("t4_last_addr", Mem_Addr, 32'h31);
        chk("t4_last_data", Mem_WriteData, 32'hB6);
        idle(); at_neg();
        chk("t4_empty", Empty, 1);
        chk("t4_dropped", dut_mem.exists(32'h30), 0);
        chk("t4_drops", drops, 1);

        // reset mid-operation discards pending stores
        for (int i = 0; i < 3; i++) drive(1, 32'h40 + i, 32'hC0 + i, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 1); at_neg();
        chk("t5_count3", Count, 3);
        drive(0, 0, 0, 0, 0, 0); at_neg();
        chk("t5_count0", Count, 0);
        chk("t5_empty", Empty, 1);
        chk("t5_wr", Mem_Write, 0);
        idle(); idle(); at_neg();
        chk("t5_no_41", dut_mem.exists(32'h41), 0);
        chk("t5_no_42", dut_mem.exists(32'h42), 0);

        // alternating loads: one drain per load-free cycle, program order
        drive(1, 32'h50, 32'h61, 1, 32'h50, 0);
        drive(1, 32'h50, 32'h62, 1, 32'h50, 0);
        w0 = nwrites;
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 32'h50, 0); at_neg();
        chk("t6_fwd", Ld_Data, 32'h62);
        chk("t6_one_write", nwrites - w0, 1);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 32'h50, 0); at_neg();
        chk("t6_two_writes", nwrites - w0, 2);
        chk("t6_mem", dut_mem[32'h50], 32'h62);
        chk("t6_empty", Empty, 1);

        // randomized traffic
        for (int n = 0; n < 3000; n++)
            drive($urandom_range(0, 99) < 55, $urandom_range(0, 7), $urandom,
                  $urandom_range(0, 99) < 40, $urandom_range(0, 7),
                  $urandom_range(0, 249) == 0);
        for (int n = 0; n < DEPTH + 2; n++) idle();
        at_neg();
        chk("final_empty", Empty, 1);
        chk("mem_size", dut_mem.size(), ref_mem.size());
        foreach (ref_mem[k]) begin
            if (!dut_mem.exists(k)) chk("mem_missing", 0, 1);
            else chk("mem_word", dut_mem[k], ref_mem[k]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
